vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Pixel-clock-domain raster timing generator for the VGA output path. It runs on the 25 MHz pixel clock from the VGA PLL and gates itself on the PLL `locked` flag. It produces registered hsync/vsync, the active-video flag, current pixel coordinates and a start-of-frame pulse. Downstream framebuffer-read and colour logic consume these outputs.

## Interface
Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE_LOW, 1, 1 = sync pulses drive 0 when asserted

Ports:
- refclk  in  1  pixel clock, 25 MHz; all logic on the rising edge
- rst  in  1  asynchronous reset, active-low
- locked  in  1  PLL lock flag, asynchronous to refclk
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- video_on  out  1  high while the output position is inside the visible area
- pixel_x  out  10  output horizontal position, 0..H_TOTAL-1
- pixel_y  out  10  output vertical position, 0..V_TOTAL-1
- frame_start  out  1  one-cycle pulse when the output position is (0,0)

## Operation
- Derived constants: H_TOTAL = sum of the four H parameters (default 800); V_TOTAL = sum of the four V parameters (default 525). Both must be ≤ 1024. Counters are 10 bits wide.
- `locked` passes through a 2-flop synchronizer; its output is `run`.
- State is held in the synchronizer flops, h_cnt, v_cnt, and the output registers.
- Counter behaviour:
  - run=0: h_cnt and v_cnt clear to 0 synchronously, and all outputs take their reset values.
  - run=1, h_cnt < H_TOTAL-1: h_cnt increments by 1.
  - run=1, h_cnt = H_TOTAL-1: h_cnt wraps to 0, and v_cnt increments; if v_cnt = V_TOTAL-1, v_cnt wraps to 0.
- Output registers load from the pre-increment counter values on each run=1 edge:
  - pixel_x = h_cnt
  - pixel_y = v_cnt
  - video_on = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE)
  - hsync asserted for h_cnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]; default range 656..751
  - vsync asserted for v_cnt in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1]; default range 490..491; asserted for whole lines
  - frame_start = (h_cnt = 0) && (v_cnt = 0)
- Asserted level of hsync/vsync is 0 when SYNC_ACTIVE_LOW=1, and 1 otherwise.
- Reset values (rst low, or run=0):
  - h_cnt = v_cnt = 0, pixel_x = pixel_y = 0
  - video_on = 0, frame_start = 0
  - hsync = vsync = deasserted level (1 for default polarity)
  - synchronizer flops = 0
- Lock loss mid-frame: the raster aborts. On relock, the raster restarts from (0,0) with a fresh frame_start. There is no partial-frame resume.
- Reset asserted mid-operation: all state clears immediately (asynchronously). Restart follows the same rules as relock.

## Timing
- locked rise to run=1: 2 refclk edges.
- Counter to output latency: 1 cycle. Outputs always describe the position the counters held on the previous edge, so the sync, video_on and coordinate outputs are mutually consistent.
- Startup sequence: let cycle 0 be the first edge with run=1, where the counters hold (0,0). At cycle 1, the outputs show (0,0) with video_on=1 and frame_start=1.
- Line period: exactly H_TOTAL cycles. Frame period: exactly H_TOTAL×V_TOTAL cycles (420000 at default settings).
- frame_start: exactly one cycle per frame, no gaps.
- locked fall to outputs at reset values: 3 edges (2 synchronizer edges, then 1 clear edge).

## Test plan
- Reset and idle: hold rst=0, then release with locked=0 for 100 cycles. Required: hsync=vsync=1, video_on=0, pixel_x=pixel_y=0, frame_start=0 throughout.
- Startup: raise locked. Required: at the 3rd edge after the rise, outputs are (0,0) with video_on=1 and frame_start=1. At the 4th edge, pixel_x=1 and frame_start=0.
- Horizontal timing: over one line, count cycles. Required:
  - video_on high for 640 consecutive cycles
  - hsync low for exactly 96 cycles, beginning when pixel_x=656
  - line period 800 cycles
- Vertical timing and wrap: run 2 full frames. Required:
  - vsync low for exactly 1600 cycles, starting at (0,490)
  - pixel_y wraps 524→0 together with pixel_x 799→0
  - frame_start pulses are exactly 420000 cycles apart
- Lock drop mid-frame: deassert locked at position (300,200) for 10 cycles, then reassert. Required:
  - outputs return to reset values within 3 edges
  - after relock, the raster restarts at (0,0) with frame_start=1 after 3 edges
- Async reset mid-line: pulse rst low for less than 1 cycle between edges. Required: outputs go to reset values immediately, without waiting for an edge, and restart follows the startup rule.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle carried from vga_timing_gen to the framebuffer-read and colour logic.
// The master drives the timing; slaves only observe it.
interface vga_timing_gen_if;
   logic       hsync;
   logic       vsync;
   logic       video_on;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic       frame_start;

   modport master (
      output hsync,
      output vsync,
      output video_on,
      output pixel_x,
      output pixel_y,
      output frame_start
   );

   modport slave (
      input hsync,
      input vsync,
      input video_on,
      input pixel_x,
      input pixel_y,
      input frame_start
   );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator on the pixel clock, gated by a synchronized PLL lock.
// The outputs are registered and describe the counter position from the previous edge.
module vga_timing_gen #(
   parameter int H_VISIBLE       = 640,
   parameter int H_FRONT         = 16,
   parameter int H_SYNC          = 96,
   parameter int H_BACK          = 48,
   parameter int V_VISIBLE       = 480,
   parameter int V_FRONT         = 10,
   parameter int V_SYNC          = 2,
   parameter int V_BACK          = 33,
   parameter int SYNC_ACTIVE_LOW = 1
) (
   input  logic              refclk,
   input  logic              rst,
   input  logic              locked,
   vga_timing_gen_if.master  vga
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
   localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
   localparam logic       SYNC_ON    = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
   localparam logic       SYNC_OFF   = (SYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

   logic       lock_meta_r;
   logic       run_r;
   logic [9:0] h_cnt_r;
   logic [9:0] v_cnt_r;
   logic       hsync_r;
   logic       vsync_r;
   logic       video_on_r;
   logic [9:0] pixel_x_r;
   logic [9:0] pixel_y_r;
   logic       frame_start_r;

   logic [9:0] h_nxt_s;
   logic [9:0] v_nxt_s;
   logic       hsync_s;
   logic       vsync_s;
   logic       video_on_s;
   logic       frame_start_s;

   // Two-flop synchronizer bringing the asynchronous PLL lock into the pixel domain.
   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         lock_meta_r <= 1'b0;
         run_r       <= 1'b0;
      end else begin
         lock_meta_r <= locked;
         run_r       <= lock_meta_r;
      end
   end

   // Next counter position and decode of the current position into output levels.
   always_comb begin
      h_nxt_s       = 10'd0;
      v_nxt_s       = v_cnt_r;
      hsync_s       = SYNC_OFF;
      vsync_s       = SYNC_OFF;
      video_on_s    = 1'b0;
      frame_start_s = 1'b0;

      if (h_cnt_r == H_LAST) begin
         h_nxt_s = 10'd0;
         if (v_cnt_r == V_LAST) begin
            v_nxt_s = 10'd0;
         end else begin
            v_nxt_s = v_cnt_r + 10'd1;
         end
      end else begin
         h_nxt_s = h_cnt_r + 10'd1;
         v_nxt_s = v_cnt_r;
      end

      if ((h_cnt_r >= HS_FIRST) && (h_cnt_r <= HS_LAST)) begin
         hsync_s = SYNC_ON;
      end else begin
         hsync_s = SYNC_OFF;
      end

      if ((v_cnt_r >= VS_FIRST) && (v_cnt_r <= VS_LAST)) begin
         vsync_s = SYNC_ON;
      end else begin
         vsync_s = SYNC_OFF;
      end

      video_on_s    = (h_cnt_r < H_VIS) && (v_cnt_r < V_VIS);
      frame_start_s = (h_cnt_r == 10'd0) && (v_cnt_r == 10'd0);
   end

   // Raster counters and output registers; losing lock aborts the frame back to (0,0).
   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         h_cnt_r       <= 10'd0;
         v_cnt_r       <= 10'd0;
         hsync_r       <= SYNC_OFF;
         vsync_r       <= SYNC_OFF;
         video_on_r    <= 1'b0;
         pixel_x_r     <= 10'd0;
         pixel_y_r     <= 10'd0;
         frame_start_r <= 1'b0;
      end else if (!run_r) begin
         h_cnt_r       <= 10'd0;
         v_cnt_r       <= 10'd0;
         hsync_r       <= SYNC_OFF;
         vsync_r       <= SYNC_OFF;
         video_on_r    <= 1'b0;
         pixel_x_r     <= 10'd0;
         pixel_y_r     <= 10'd0;
         frame_start_r <= 1'b0;
      end else begin
         h_cnt_r       <= h_nxt_s;
         v_cnt_r       <= v_nxt_s;
         hsync_r       <= hsync_s;
         vsync_r       <= vsync_s;
         video_on_r    <= video_on_s;
         pixel_x_r     <= h_cnt_r;
         pixel_y_r     <= v_cnt_r;
         frame_start_r <= frame_start_s;
      end
   end

   assign vga.hsync       = hsync_r;
   assign vga.vsync       = vsync_r;
   assign vga.video_on    = video_on_r;
   assign vga.pixel_x     = pixel_x_r;
   assign vga.pixel_y     = pixel_y_r;
   assign vga.frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default horizontal timing with a shortened
// vertical raster (6+2+2+3 = 13 lines) so whole frames fit in a short run.
module tb_vga_timing_gen;

   localparam int HT  = 800;
   localparam int VT  = 13;
   localparam int VS0 = 8;

   logic refclk;
   logic rst;
   logic locked;

   vga_timing_gen_if vif ();

   vga_timing_gen #(
      .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
      .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
      .SYNC_ACTIVE_LOW(1)
   ) dut (
      .refclk (refclk),
      .rst    (rst),
      .locked (locked),
      .vga    (vif)
   );

   initial refclk = 1'b0;
   always #20 refclk = ~refclk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic hs, input logic vs, input logic vo,
                            input int px, input int py, input logic fs);
      logic [9:0] ex_x;
      logic [9:0] ex_y;
      ex_x = px[9:0];
      ex_y = py[9:0];
      check_val(tag,
                {8'd0, vif.hsync, vif.vsync, vif.video_on, vif.pixel_x, vif.pixel_y, vif.frame_start},
                {8'd0, hs, vs, vo, ex_x, ex_y, fs});
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge refclk);
   endtask

   task automatic wait_pos(input string tag, input int x, input int y, input int budget);
      int n;
      n = 0;
      while (!((int'(vif.pixel_x) == x) && (int'(vif.pixel_y) == y)) && (n < budget)) begin
         step(1);
         n++;
      end
      check_val(tag, {31'd0, (int'(vif.pixel_x) == x) && (int'(vif.pixel_y) == y)}, 32'd1);
   endtask

   int vo_cnt, vo_run, vo_max, hs_cnt, hs_x;
   int vs_cnt, vs_x, vs_y, vs_run, vs_first_run, fs_cnt, fs_last, fs_gap_bad;
   int hs_total, vo_total, wraps, wrap_bad, pos_err, ex, ey, prev_x, prev_y, n;

   initial begin
      rst    = 1'b0;
      locked = 1'b0;
      step(3);
      check_out("reset_held", 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
      rst = 1'b1;

      // Idle with lock low: outputs must stay at reset values.
      n = 0;
      for (int i = 0; i < 100; i++) begin
         step(1);
         if (!(vif.hsync === 1'b1 && vif.vsync === 1'b1 && vif.video_on === 1'b0 &&
               vif.pixel_x === 10'd0 && vif.pixel_y === 10'd0 && vif.frame_start === 1'b0)) n++;
      end
      check_val("idle_unlocked_bad_cycles", n, 32'd0);

      // Startup from a lock rise.
      locked = 1'b1;
      step(2);
      check_out("startup_edge2", 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
      step(1);
      check_out("startup_edge3", 1'b1, 1'b1, 1'b1, 0, 0, 1'b1);
      step(1);
      check_out("startup_edge4", 1'b1, 1'b1, 1'b1, 1, 0, 1'b0);

      // One full line starting at (0,1).
      wait_pos("wait_line1", 0, 1, 2 * HT);
      vo_cnt = 0; vo_run = 0; vo_max = 0; hs_cnt = 0; hs_x = -1;
      for (int i = 0; i < HT; i++) begin
         if (vif.video_on === 1'b1) begin
            vo_cnt++;
            vo_run++;
            if (vo_run > vo_max) vo_max = vo_run;
         end else begin
            vo_run = 0;
         end
         if (vif.hsync === 1'b0) begin
            if (hs_x < 0) hs_x = int'(vif.pixel_x);
            hs_cnt++;
         end
         if (i < HT - 1) step(1);
      end
      check_val("line_video_on_cycles", vo_cnt, 32'd640);
      check_val("line_video_on_run", vo_max, 32'd640);
      check_val("line_hsync_low_cycles", hs_cnt, 32'd96);
      check_val("line_hsync_start_x", hs_x, 32'd656);
      step(1);
      check_out("line_period_next", 1'b1, 1'b1, 1'b1, 0, 2, 1'b0);

      // Two full frames from a frame_start pulse.
      n = 0;
      while (vif.frame_start !== 1'b1 && n < HT * VT + 10) begin
         step(1);
         n++;
      end
      check_out("frame_start_seen", 1'b1, 1'b1, 1'b1, 0, 0, 1'b1);
      vs_cnt = 0; vs_x = -1; vs_y = -1; vs_run = 0; vs_first_run = -1;
      fs_cnt = 0; fs_last = -1; fs_gap_bad = 0; hs_total = 0; vo_total = 0;
      wraps = 0; wrap_bad = 0; pos_err = 0; ex = 0; ey = 0; prev_x = -1; prev_y = -1;
      for (int i = 0; i <= 2 * HT * VT; i++) begin
         if (int'(vif.pixel_x) != ex || int'(vif.pixel_y) != ey) pos_err++;
         if (prev_x == HT - 1 && prev_y == VT - 1) begin
            wraps++;
            if (vif.pixel_x !== 10'd0 || vif.pixel_y !== 10'd0) wrap_bad++;
         end
         if (vif.vsync === 1'b0) begin
            if (vs_x < 0) begin
               vs_x = int'(vif.pixel_x);
               vs_y = int'(vif.pixel_y);
            end
            vs_cnt++;
            vs_run++;
         end else begin
            if (vs_run > 0 && vs_first_run < 0) vs_first_run = vs_run;
            vs_run = 0;
         end
         if (vif.hsync === 1'b0) hs_total++;
         if (vif.video_on === 1'b1) vo_total++;
         if (vif.frame_start === 1'b1) begin
            if (fs_last >= 0 && (i - fs_last) != HT * VT) fs_gap_bad++;
            fs_last = i;
            fs_cnt++;
         end
         prev_x = int'(vif.pixel_x);
         prev_y = int'(vif.pixel_y);
         ex = ex + 1;
         if (ex == HT) begin
            ex = 0;
            ey = (ey == VT - 1) ? 0 : ey + 1;
         end
         if (i < 2 * HT * VT) step(1);
      end
      check_val("frame_position_errors", pos_err, 32'd0);
      check_val("frame_vsync_low_cycles", vs_cnt, 32'd3200);
      check_val("frame_vsync_first_run", vs_first_run, 32'd1600);
      check_val("frame_vsync_start_x", vs_x, 32'd0);
      check_val("frame_vsync_start_y", vs_y, VS0);
      check_val("frame_wrap_count", wraps, 32'd2);
      check_val("frame_wrap_bad", wrap_bad, 32'd0);
      check_val("frame_start_count", fs_cnt, 32'd3);
      check_val("frame_start_gap_bad", fs_gap_bad, 32'd0);
      check_val("frame_hsync_low_cycles", hs_total, 32'd2496);
      check_val("frame_video_on_cycles", vo_total, 32'd7681);

      // Lock drop mid-frame at (300,5).
      wait_pos("wait_lockdrop_pos", 300, 5, 2 * HT * VT);
      locked = 1'b0;
      step(2);
      check_out("lockdrop_edge2", 1'b1, 1'b1, 1'b1, 302, 5, 1'b0);
      step(1);
      check_out("lockdrop_edge3", 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
      step(7);
      check_out("lockdrop_hold", 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
      locked = 1'b1;
      step(2);
      check_out("relock_edge2", 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
      step(1);
      check_out("relock_edge3", 1'b1, 1'b1, 1'b1, 0, 0, 1'b1);
      step(1);
      check_out("relock_edge4", 1'b1, 1'b1, 1'b1, 1, 0, 1'b0);

      // Short asynchronous reset pulse between edges.
      step(50);
      check_out("pre_rst_pos", 1'b1, 1'b1, 1'b1, 51, 0, 1'b0);
      #5 rst = 1'b0;
      #1 check_out("rst_async_clear", 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
      #4 rst = 1'b1;
      step(2);
      check_out("rst_restart_edge2", 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
      step(1);
      check_out("rst_restart_edge3", 1'b1, 1'b1, 1'b1, 0, 0, 1'b1);
      step(1);
      check_out("rst_restart_edge4", 1'b1, 1'b1, 1'b1, 1, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
